// File: rtl/cnn_window_ctrl.sv
// ---------------------------------------------------------------------------
// cnn_window_ctrl
//   Sequencing controller for a 3x3 CNN line buffer. Accepts a raster-order
//   pixel stream (valid/ready), strobes the line buffer write, tracks the
//   row/column of the incoming pixel and raises a window-valid flag with the
//   window centre coordinates once a full 3x3 neighbourhood is stored.
//   The upstream stream is back-pressured while a window waits to be taken.
//   An abort mid-row issues dummy write strobes to the end of the row so the
//   line buffer's own column pointer lands back on column 0.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         one-cycle pulse, begins a frame when idle
//   abort_i         synchronous abort of the current frame
//   in_valid_i      upstream pixel valid
//   in_ready_o      controller can accept a pixel
//   lb_valid_o      line buffer write strobe
//   win_valid_o     3x3 window available
//   win_ready_i     downstream takes the window
//   win_row_o/col_o window centre coordinates
//   busy_o          frame in progress (any state but idle)
//   done_o          one-cycle pulse at frame completion
// ---------------------------------------------------------------------------
module cnn_window_ctrl #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             lb_valid_o,
  output logic             win_valid_o,
  input  logic             win_ready_i,
  output logic [CNT_W-1:0] win_row_o,
  output logic [CNT_W-1:0] win_col_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_FLUSH} state_e;

  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic             win_valid_q, win_valid_d;
  logic [CNT_W-1:0] win_row_q, win_row_d;
  logic [CNT_W-1:0] win_col_q, win_col_d;
  logic             done_q, done_d;

  logic accept;
  logic win_hs;
  logic col_last;
  logic row_last;

  assign win_hs   = win_valid_q && win_ready_i;
  assign col_last = (col_q == COL_MAX);
  assign row_last = (row_q == ROW_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    done_d      = 1'b0;

    // Ready only depends on registered state and the consumer, so it can
    // never form a loop with an upstream that waits on ready.
    in_ready_o  = (state_q == S_RUN) && !(win_valid_q && !win_ready_i);
    // An abort cycle writes nothing: the flush that follows counts strobes
    // from the column the abort was seen at.
    accept      = in_ready_o && in_valid_i && !abort_i;
    lb_valid_o  = accept || (state_q == S_FLUSH);
    busy_o      = (state_q != S_IDLE);

    // A taken window clears; a new window set below overrides this, giving
    // back-to-back windows at one per cycle.
    if (win_hs) win_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
        end
      end

      S_RUN, S_LAST: begin
        if (abort_i) begin
          win_valid_d = 1'b0;
          if (col_q == '0) begin
            state_d = S_IDLE;
            row_d   = '0;
          end else begin
            state_d = S_FLUSH;
          end
        end else if (state_q == S_RUN) begin
          if (accept) begin
            // Pixel (r,c) completes the window centred on (r-1,c-1).
            if (row_q >= TWO && col_q >= TWO) begin
              win_valid_d = 1'b1;
              win_row_d   = row_q - ONE;
              win_col_d   = col_q - ONE;
            end
            if (col_last) begin
              col_d = '0;
              if (row_last) begin
                state_d = S_LAST;
                row_d   = '0;
              end else begin
                row_d   = row_q + ONE;
              end
            end else begin
              col_d = col_q + ONE;
            end
          end
        end else if (win_hs) begin
          // Final window taken: frame complete.
          done_d  = 1'b1;
          state_d = S_IDLE;
          row_d   = '0;
          col_d   = '0;
        end
      end

      S_FLUSH: begin
        // One dummy strobe per cycle up to and including the last column.
        if (col_last) begin
          state_d = S_IDLE;
          row_d   = '0;
          col_d   = '0;
        end else begin
          col_d   = col_q + ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign win_valid_o = win_valid_q;
  assign win_row_o   = win_row_q;
  assign win_col_o   = win_col_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_cnn_window_ctrl.sv
// Bench for cnn_window_ctrl: a 28x28 instance and a 5x4 instance driven by
// directed sequences, checked every cycle against a pixel-index model plus
// literal frame-level expectations.
module tb_cnn_window_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 28x28 instance
  logic       a_start, a_abort, a_in_valid, a_in_ready, a_lb, a_wv, a_win_ready;
  logic       a_busy, a_done;
  logic [9:0] a_row, a_col;
  // 5x4 instance
  logic       b_start, b_abort, b_in_valid, b_in_ready, b_lb, b_wv, b_win_ready;
  logic       b_busy, b_done;
  logic [3:0] b_row, b_col;

  cnn_window_ctrl #(.WIDTH(28), .HEIGHT(28), .CNT_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(a_start), .abort_i(a_abort),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .lb_valid_o(a_lb),
    .win_valid_o(a_wv), .win_ready_i(a_win_ready), .win_row_o(a_row),
    .win_col_o(a_col), .busy_o(a_busy), .done_o(a_done));

  cnn_window_ctrl #(.WIDTH(5), .HEIGHT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .abort_i(b_abort),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .lb_valid_o(b_lb),
    .win_valid_o(b_wv), .win_ready_i(b_win_ready), .win_row_o(b_row),
    .win_col_o(b_col), .busy_o(b_busy), .done_o(b_done));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Model: a frame is the count n of pixels accepted; pixel n sits at
  // (n / W, n % W). phase 0 idle, 1 streaming, 2 waiting last window, 3 flush.
  typedef struct packed {
    int   phase;
    int   n;
    logic wv;
    int   wr;
    int   wc;
    logic done;
    int   fl;
  } mdl_t;

  mdl_t mA, mB;

  function automatic mdl_t step(mdl_t m, int W, int H, logic st, logic ab,
                                logic iv, logic wr);
    mdl_t x;
    logic rdy, acc, hs;
    int   r, c;
    x      = m;
    rdy    = (m.phase == 1) && !(m.wv && !wr);
    acc    = rdy && iv && !ab;
    hs     = m.wv && wr;
    x.done = 1'b0;
    case (m.phase)
      0: if (st) begin x.phase = 1; x.n = 0; end
      1: begin
        if (ab) begin
          x.wv = 1'b0;
          if (m.n % W == 0) x.phase = 0;
          else begin x.phase = 3; x.fl = W - (m.n % W); end
        end else begin
          if (hs) x.wv = 1'b0;
          if (acc) begin
            r = m.n / W;
            c = m.n % W;
            if (r >= 2 && c >= 2) begin x.wv = 1'b1; x.wr = r - 1; x.wc = c - 1; end
            x.n = m.n + 1;
            if (x.n == W * H) x.phase = 2;
          end
        end
      end
      2: begin
        if (ab) begin x.wv = 1'b0; x.phase = 0; end
        else if (hs) begin x.wv = 1'b0; x.done = 1'b1; x.phase = 0; end
      end
      default: begin
        x.fl = m.fl - 1;
        if (x.fl == 0) x.phase = 0;
      end
    endcase
    return x;
  endfunction

  task automatic cmp(string p, mdl_t m, logic iv, logic ab, logic wr,
                     logic rdy, logic lb, logic wv, int row, int col,
                     logic busy, logic done);
    logic erdy, elb;
    erdy = (m.phase == 1) && !(m.wv && !wr);
    elb  = (erdy && iv && !ab) || (m.phase == 3);
    chk({p, ".in_ready"},  int'(rdy),  int'(erdy));
    chk({p, ".lb_valid"},  int'(lb),   int'(elb));
    chk({p, ".win_valid"}, int'(wv),   int'(m.wv));
    chk({p, ".busy"},      int'(busy), int'(m.phase != 0));
    chk({p, ".done"},      int'(done), int'(m.done));
    if (m.wv) begin
      chk({p, ".win_row"}, row, m.wr);
      chk({p, ".win_col"}, col, m.wc);
    end
  endtask

  // Tallies
  int a_lb_cnt = 0, a_win_cnt = 0, a_done_cnt = 0, a_last_r = -1, a_last_c = -1;
  int a_first_lb = -1, a_first_r = -1, a_first_c = -1;
  logic a_first_seen = 1'b0;
  int b_done_cnt = 0;
  int b_wr_q[$];
  int b_wc_q[$];

  // Compare process: samples on the falling edge, then advances the model
  // across the coming rising edge.
  initial begin
    mA = '0;
    mB = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mA = '0;
        mB = '0;
        chk("A.rst_row", int'(a_row), 0);
        chk("A.rst_col", int'(a_col), 0);
        chk("B.rst_row", int'(b_row), 0);
        chk("B.rst_col", int'(b_col), 0);
      end
      cmp("A", mA, a_in_valid, a_abort, a_win_ready, a_in_ready, a_lb, a_wv,
          int'(a_row), int'(a_col), a_busy, a_done);
      cmp("B", mB, b_in_valid, b_abort, b_win_ready, b_in_ready, b_lb, b_wv,
          int'(b_row), int'(b_col), b_busy, b_done);
      if (a_wv && !a_first_seen) begin
        a_first_seen = 1'b1;
        a_first_lb   = a_lb_cnt;
        a_first_r    = int'(a_row);
        a_first_c    = int'(a_col);
      end
      if (a_lb) a_lb_cnt++;
      if (a_wv && a_win_ready) begin
        a_win_cnt++;
        a_last_r = int'(a_row);
        a_last_c = int'(a_col);
      end
      if (a_done) a_done_cnt++;
      if (b_wv && b_win_ready) begin
        b_wr_q.push_back(int'(b_row));
        b_wc_q.push_back(int'(b_col));
      end
      if (b_done) b_done_cnt++;
      if (rst_n) begin
        mA = step(mA, 28, 28, a_start, a_abort, a_in_valid, a_win_ready);
        mB = step(mB, 5, 4, b_start, b_abort, b_in_valid, b_win_ready);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_done(string nm, int d0, int budget);
    int n = 0;
    while (a_done_cnt == d0 && n < budget) begin tick(); n++; end
    chk(nm, int'(a_done_cnt != d0), 1);
  endtask

  task automatic wait_a_lb(string nm, int target, int budget);
    int n = 0;
    while (a_lb_cnt != target && n < budget) begin tick(); n++; end
    chk(nm, a_lb_cnt, target);
  endtask

  initial begin
    int lb0, w0, d0, n;
    int exp_r[6];
    int exp_c[6];
    exp_r = '{1, 1, 1, 2, 2, 2};
    exp_c = '{1, 2, 3, 1, 2, 3};

    rst_n = 1'b0;
    a_start = 1'b0; a_abort = 1'b0; a_in_valid = 1'b1; a_win_ready = 1'b0;
    b_start = 1'b0; b_abort = 1'b0; b_in_valid = 1'b1; b_win_ready = 1'b0;
    repeat (10) tick();
    chk("A.reset_strobes", a_lb_cnt, 0);
    chk("A.reset_in_ready", int'(a_in_ready), 0);
    rst_n = 1'b1;
    tick();

    // Abort while idle is ignored.
    a_abort = 1'b1; tick(); a_abort = 1'b0;
    chk("A.idle_abort_busy", int'(a_busy), 0);

    // Frame 1: continuous stream, consumer always ready, stray start mid-run.
    a_win_ready = 1'b1;
    a_start = 1'b1; tick(); a_start = 1'b0;
    lb0 = a_lb_cnt; w0 = a_win_cnt; d0 = a_done_cnt;
    n = 0;
    while (a_done_cnt == d0 && n < 3000) begin
      a_start = (n == 300);
      tick();
      n++;
    end
    a_start = 1'b0;
    chk("A.f1_done_seen", int'(a_done_cnt != d0), 1);
    repeat (3) tick();
    // First window follows the 59th accept (index 58): pixel (2,2).
    chk("A.f1_first_win_accepts", a_first_lb, 59);
    chk("A.f1_first_row", a_first_r, 1);
    chk("A.f1_first_col", a_first_c, 1);
    chk("A.f1_windows", a_win_cnt - w0, 676);
    chk("A.f1_last_row", a_last_r, 26);
    chk("A.f1_last_col", a_last_c, 26);
    chk("A.f1_strobes", a_lb_cnt - lb0, 784);
    chk("A.f1_done_pulses", a_done_cnt - d0, 1);

    // Frame 2: start with abort together in idle, stall at window (3,7).
    a_start = 1'b1; a_abort = 1'b1; tick(); a_start = 1'b0; a_abort = 1'b0;
    lb0 = a_lb_cnt; w0 = a_win_cnt; d0 = a_done_cnt;
    n = 0;
    while (!(a_wv && a_row == 10'd3 && a_col == 10'd7) && n < 500) begin tick(); n++; end
    chk("A.f2_window_3_7_seen", int'(a_wv && a_row == 10'd3 && a_col == 10'd7), 1);
    a_win_ready = 1'b0;
    n = a_lb_cnt;
    repeat (5) tick();
    chk("A.f2_stall_strobes", a_lb_cnt - n, 0);
    chk("A.f2_stall_in_ready", int'(a_in_ready), 0);
    chk("A.f2_stall_row", int'(a_row), 3);
    chk("A.f2_stall_col", int'(a_col), 7);
    a_win_ready = 1'b1;
    wait_a_done("A.f2_done_seen", d0, 3000);
    chk("A.f2_windows", a_win_cnt - w0, 676);
    chk("A.f2_strobes", a_lb_cnt - lb0, 784);

    // Frame 3: abort at col 10 of row 5 -> 18 flush strobes, no done.
    tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    lb0 = a_lb_cnt; d0 = a_done_cnt;
    wait_a_lb("A.f3_reach_150", lb0 + 150, 1000);
    a_in_valid = 1'b0; a_abort = 1'b1;
    n = a_lb_cnt;
    tick();
    a_abort = 1'b0; a_in_valid = 1'b1;
    chk("A.f3_win_cleared", int'(a_wv), 0);
    chk("A.f3_flush_in_ready", int'(a_in_ready), 0);
    repeat (24) tick();
    chk("A.f3_flush_strobes", a_lb_cnt - n, 18);
    chk("A.f3_no_done", a_done_cnt - d0, 0);
    chk("A.f3_idle_after", int'(a_busy), 0);

    // Frame 4: abort at col 0 -> straight to idle, no strobes.
    a_start = 1'b1; tick(); a_start = 1'b0;
    lb0 = a_lb_cnt;
    wait_a_lb("A.f4_reach_84", lb0 + 84, 1000);
    a_in_valid = 1'b0; a_abort = 1'b1;
    n = a_lb_cnt;
    tick();
    a_abort = 1'b0; a_in_valid = 1'b1;
    chk("A.f4_idle_next", int'(a_busy), 0);
    repeat (10) tick();
    chk("A.f4_flush_strobes", a_lb_cnt - n, 0);

    // 5x4 frame with random handshakes.
    b_start = 1'b1; tick(); b_start = 1'b0;
    d0 = b_done_cnt;
    n = 0;
    while (b_done_cnt == d0 && n < 2000) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_win_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    b_win_ready = 1'b1;
    chk("B.done_seen", int'(b_done_cnt != d0), 1);
    chk("B.windows", b_wr_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < b_wr_q.size()) begin
        chk($sformatf("B.win%0d_row", i), b_wr_q[i], exp_r[i]);
        chk($sformatf("B.win%0d_col", i), b_wc_q[i], exp_c[i]);
      end
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_window_ctrl.md
Name: cnn_window_ctrl

Overview:
- Sequencing controller for the 3x3 CNN line buffer.
- Accepts a raster-order pixel stream with a valid/ready handshake and drives the line buffer's write strobe.
- Tracks row/column position, flags when a full 3x3 window is available, and reports its centre coordinates.
- Applies backpressure until the window is consumed; handles frame start, frame completion and abort, including re-aligning the line buffer column pointer after an abort.

Parameters:
- WIDTH, 28, image width in pixels; must be >= 3.
- HEIGHT, 28, image height in pixels; must be >= 3.
- CNT_W, 10, width of row/column counters and coordinate outputs; 2^CNT_W must exceed max(WIDTH, HEIGHT).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; begins a frame when IDLE
- abort_i  in  1  synchronous abort of the current frame
- in_valid_i  in  1  upstream pixel valid
- in_ready_o  out  1  controller can accept a pixel
- lb_valid_o  out  1  write strobe to the line buffer (its valid_in)
- win_valid_o  out  1  3x3 window in the line buffer is valid
- win_ready_i  in  1  downstream consumes the window
- win_row_o  out  CNT_W  row of the window centre
- win_col_o  out  CNT_W  column of the window centre
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; row=col=0; win_valid_o=0; win_row_o=win_col_o=0; done_o=0; in_ready_o=0; lb_valid_o=0; busy_o=0.
- States: IDLE, RUN, LAST, FLUSH.
- IDLE:
  - in_ready_o=0; in_valid_i is ignored.
  - start_i -> RUN, row=col=0.
- RUN:
  - in_ready_o = !(win_valid_o && !win_ready_i). The output is combinational from registered state and win_ready_i; it never depends on in_valid_i.
  - Accept = in_valid_i && in_ready_o.
  - lb_valid_o = accept, in the same cycle. The line buffer writes on that edge.
  - On accept of pixel (r,c): col increments and wraps at WIDTH-1 to 0, incrementing row.
  - If r>=2 && c>=2: next cycle win_valid_o=1, win_row_o=r-1, win_col_o=c-1.
- Window hold:
  - win_valid_o stays high with stable coordinates until win_ready_i=1; it clears the following cycle unless a new window is set that same edge.
  - A window consumed in the same cycle as a new accept is legal: back-to-back windows, throughput 1 per cycle.
  - Rows 0-1 and columns 0-1 never produce windows. Window count per frame = (HEIGHT-2)*(WIDTH-2).
- Last pixel: accept of (HEIGHT-1, WIDTH-1) -> LAST. Always produces a window.
- LAST:
  - in_ready_o=0.
  - On the window handshake (win_valid_o && win_ready_i): next cycle done_o=1 for one cycle, state=IDLE, row=col=0.
- Abort (abort_i in RUN or LAST; priority over all else):
  - win_valid_o cleared next cycle; no done_o pulse.
  - If col==0: -> IDLE.
  - Otherwise -> FLUSH.
- FLUSH:
  - in_ready_o=0; lb_valid_o=1 every cycle; col increments.
  - When col reaches WIDTH-1 (that pulse included): -> IDLE, row=col=0.
  - Exactly WIDTH-col dummy strobes are issued, re-aligning the line buffer column counter to 0.
- Ignored inputs:
  - abort_i in IDLE or FLUSH.
  - start_i in any non-IDLE state.
- Simultaneous start_i and abort_i in IDLE: start wins.
- Reset mid-frame: immediate return to reset values. Line buffer alignment is the line buffer's own reset's responsibility.

Test Plan:
- Reset with in_valid_i=1, start_i=0 -> all outputs 0, in_ready_o=0, no lb_valid_o strobes for 10 cycles.
- 28x28 frame, in_valid_i=1 continuous, win_ready_i=1:
  - first win_valid_o one cycle after accept #58, with row=1, col=1.
  - 676 windows total, last at (26,26).
  - done_o pulse one cycle after last handshake; exactly 784 lb_valid_o strobes.
- win_ready_i=0 for 5 cycles while win_valid_o=1 at (3,7) -> in_ready_o=0, no lb_valid_o strobes, coordinates stable; release -> stream resumes with no pixel lost.
- Abort after 5*28+10 pixels accepted (col=10) -> win_valid_o=0 next cycle; 18 consecutive lb_valid_o pulses with in_ready_o=0; then IDLE; no done_o.
- Abort at col=0 -> direct to IDLE with zero flush strobes.
- start_i pulsed mid-RUN -> ignored, counters unaffected.
- WIDTH=5, HEIGHT=4 frame with random in_valid_i/win_ready_i -> exactly 6 windows, at (1..2, 1..3) in raster order.
